// File: rtl/dm_responder.sv
// Data-memory responder: word RAM with byte-lane merge, power-up clear sweep,
// and a valid/ready trace FIFO recording every committed write.
//
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   data_addr       - byte address from CPU (bits[1:0] ignored by RAM)
//   data_wd         - lane-positioned write data
//   data_byte_we    - per-byte write enables
//   data_pc         - issuing PC, recorded in trace only
//   data_rd         - aligned word read, 0 while clearing or out of range
//   busy            - clear sweep in progress
//   oor_err         - pulse: previous-cycle access was out of range
//   trace_valid/ready, trace_pc/addr/data - trace FIFO head handshake
//   trace_overflow  - sticky: a trace record was dropped
module dm_responder #(
  parameter int DEPTH_WORDS = 3072,
  parameter int TRACE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wd,
  input  logic [3:0]  data_byte_we,
  input  logic [31:0] data_pc,
  output logic [31:0] data_rd,
  output logic        busy,
  output logic        oor_err,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic        trace_overflow
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(TRACE_DEPTH);
  localparam logic [31:0] LAST_ADDR = 32'(DEPTH_WORDS * 4 - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(TRACE_DEPTH);

  typedef enum logic {CLEAR, READY} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_t;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic          clr_we;

  logic [31:0]   mem [DEPTH_WORDS];
  trace_t        fifo_q [TRACE_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q, cnt_d;
  logic          ovf_q, oor_q;

  logic [AW-1:0] idx;
  logic          in_range, is_ready;
  logic          wr_req, push, pop, full;
  logic [31:0]   cur_word, merged;
  logic          unused;

  assign idx      = data_addr[AW+1:2];
  assign in_range = data_addr <= LAST_ADDR;
  assign is_ready = state_q == READY;
  assign unused   = ^data_addr[1:0];

  assign cur_word = mem[idx];
  assign data_rd  = (is_ready && in_range) ? cur_word : '0;
  assign busy     = state_q == CLEAR;
  assign oor_err  = oor_q;

  always_comb begin
    merged = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (data_byte_we[i]) merged[8*i +: 8] = data_wd[8*i +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_we    = 1'b0;
    unique case (state_q)
      CLEAR: begin
        clr_we    = 1'b1;
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == LAST_IDX) begin
          state_d   = READY;
          clr_idx_d = '0;
        end
      end
      READY: ;
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // CPU writes only land in READY; clearing writes only in CLEAR.
  assign wr_req = is_ready && !reset && in_range && (data_byte_we != 4'b0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clr_we) mem[clr_idx_q] <= '0;
      else if (wr_req) mem[idx] <= merged;
    end
  end

  assign trace_valid = cnt_q != '0;
  assign full        = cnt_q == FULL_CNT;
  assign pop         = trace_valid && trace_ready;
  // A full FIFO can still accept when the head leaves the same cycle.
  assign push        = wr_req && (!full || pop);

  assign trace_pc       = fifo_q[rd_ptr_q].pc;
  assign trace_addr     = fifo_q[rd_ptr_q].addr;
  assign trace_data     = fifo_q[rd_ptr_q].data;
  assign trace_overflow = ovf_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + (PW+1)'(1);
    if (pop && !push) cnt_d = cnt_q - (PW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{data_pc, {data_addr[31:2], 2'b00}, merged};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      oor_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
      if (wr_req && !push) ovf_q <= 1'b1;
      oor_q <= is_ready && !in_range;
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: model RAM plus a trace scoreboard
// queue filled on stimulus and drained when the DUT pops a record.
module tb_dm_responder;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_addr, data_wd, data_pc;
  logic [3:0]  data_byte_we;
  logic [31:0] data_rd;
  logic        busy, oor_err, trace_valid, trace_ready;
  logic [31:0] trace_pc, trace_addr, trace_data;
  logic        trace_overflow;

  logic [31:0] mdl [3072];
  rec_t        sb [$];
  logic        mdl_ready = 1'b0;
  logic        exp_ovf = 1'b0;
  int          n_cmp = 0;
  int          n_mis = 0;
  int          n_pops = 0;

  dm_responder dut (
    .clk(clk), .reset(reset),
    .data_addr(data_addr), .data_wd(data_wd),
    .data_byte_we(data_byte_we), .data_pc(data_pc),
    .data_rd(data_rd), .busy(busy), .oor_err(oor_err),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_addr(trace_addr),
    .trace_data(trace_data), .trace_overflow(trace_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (trace_valid === 1'b1 && trace_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexp_pop", 32'd1, 32'd0);
      end else begin
        rec_t r;
        r = sb.pop_front();
        chk("tr_pc", trace_pc, r.pc);
        chk("tr_addr", trace_addr, r.addr);
        chk("tr_data", trace_data, r.data);
        n_pops++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd,
                    input logic [3:0] we, input logic [31:0] pc);
    logic [31:0] m;
    data_addr    = a;
    data_wd      = wd;
    data_byte_we = we;
    data_pc      = pc;
    if (mdl_ready && a <= 32'h2fff) begin
      m = mdl[a[13:2]];
      for (int i = 0; i < 4; i++)
        if (we[i]) m[8*i +: 8] = wd[8*i +: 8];
      mdl[a[13:2]] = m;
      if (sb.size() < 4 || (trace_ready && sb.size() > 0))
        sb.push_back('{pc, {a[31:2], 2'b00}, m});
      else
        exp_ovf = 1'b1;
    end
    tick();
    data_byte_we = 4'b0;
    data_addr    = 32'h0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a,
                    input logic [31:0] exp);
    data_addr    = a;
    data_byte_we = 4'b0;
    #1;
    chk(tag, data_rd, exp);
    tick();
    data_addr = 32'h0;
  endtask

  task automatic sweep(input string tag);
    int n;
    reset     = 1'b1;
    mdl_ready = 1'b0;
    tick();
    reset = 1'b0;
    sb.delete();
    exp_ovf = 1'b0;
    chk({tag, "_busy0"}, busy, 1);
    chk({tag, "_tv0"}, trace_valid, 0);
    chk({tag, "_ovf0"}, trace_overflow, 0);
    chk({tag, "_oor0"}, oor_err, 0);
    chk({tag, "_rd0"}, data_rd, 0);
    n = 0;
    while (busy === 1'b1 && n < 4000) begin
      tick();
      n++;
    end
    chk({tag, "_len"}, n, 3072);
    for (int i = 0; i < 3072; i++) mdl[i] = 32'h0;
    mdl_ready = 1'b1;
  endtask

  initial begin
    int p0;
    reset        = 1'b1;
    data_addr    = 32'h0;
    data_wd      = 32'h0;
    data_byte_we = 4'b0;
    data_pc      = 32'h0;
    trace_ready  = 1'b1;
    repeat (3) tick();
    sweep("init");

    wr(32'h0, 32'hCAFEF00D, 4'hF, 32'h10);
    wr(32'h1000, 32'h12345678, 4'hF, 32'h14);
    wr(32'h2ffc, 32'h87654321, 4'hF, 32'h18);
    rd("pre_2ffc", 32'h2ffc, mdl[12'hbff]);
    repeat (2) tick();
    sweep("swp");
    rd("clr_0", 32'h0, 32'h0);
    rd("clr_1000", 32'h1000, 32'h0);
    rd("clr_2ffc", 32'h2ffc, 32'h0);

    p0 = n_pops;
    wr(32'h100, 32'h11223344, 4'b1111, 32'h1000);
    wr(32'h100, 32'h0000AB00, 4'b0010, 32'h1004);
    rd("merge", 32'h100, 32'h1122AB44);
    tick();
    chk("merge_pops", n_pops - p0, 2);

    wr(32'h102, 32'hBEEF0000, 4'b1100, 32'h1008);
    rd("half", 32'h100, 32'hBEEFAB44);

    p0 = n_pops;
    wr(32'h3000, 32'hFFFFFFFF, 4'hF, 32'h100C);
    chk("oor_pulse", oor_err, 1);
    tick();
    chk("oor_clr", oor_err, 0);
    chk("oor_pops", n_pops - p0, 0);
    rd("oor_rd0", 32'h0, mdl[0]);
    rd("edge_2fff", 32'h2fff, mdl[12'hbff]);
    chk("edge_oor", oor_err, 0);
    rd("oor_rd", 32'h3000, 32'h0);
    chk("oor_rdpulse", oor_err, 1);

    repeat (2) tick();
    trace_ready = 1'b0;
    p0 = n_pops;
    for (int i = 0; i < 5; i++)
      wr(32'h200 + 32'(4*i), 32'hA0000000 + 32'(i), 4'hF, 32'h3000 + 32'(4*i));
    chk("full_tv", trace_valid, 1);
    chk("full_ovf", trace_overflow, exp_ovf);
    chk("full_head", trace_pc, 32'h3000);
    tick();
    chk("hold_head", trace_pc, 32'h3000);
    trace_ready = 1'b1;
    repeat (5) tick();
    chk("drain_pops", n_pops - p0, 4);
    chk("drain_empty", trace_valid, 0);
    for (int i = 0; i < 5; i++)
      rd("full_mem", 32'h200 + 32'(4*i), 32'hA0000000 + 32'(i));

    trace_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      wr(32'h400 + 32'(4*i), 32'h5A5A0000 + 32'(i), 4'hF, 32'h4000 + 32'(4*i));
    trace_ready = 1'b1;
    p0 = n_pops;
    wr(32'h410, 32'h77777777, 4'hF, 32'h4010);
    repeat (6) tick();
    chk("pp_pops", n_pops - p0, 5);
    chk("ovf_sticky", trace_overflow, 1);

    reset     = 1'b1;
    mdl_ready = 1'b0;
    tick();
    reset = 1'b0;
    sb.delete();
    p0 = n_pops;
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) wr(32'h2ff0, 32'hDEADBEEF, 4'hF, 32'h5000);
      else tick();
    end
    chk("mid_busy", busy, 1);
    rd("mid_rd", 32'h2ff0, 32'h0);
    chk("mid_pops", n_pops - p0, 0);
    sweep("rst2");
    rd("clrw_rd", 32'h2ff0, 32'h0);
    chk("clrw_pops", n_pops - p0, 0);
    chk("rst_ovf", trace_overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
